// File: rtl/sram_arb_pkg.sv
// Shared types, constants and helpers for the SRAM port arbiter.
// Imported by rr_pick and sram_port_arbiter.
package sram_arb_pkg;

  localparam int RSP_IDLE_DATA = 0;
  localparam int PTR_RESET     = 0;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (rotate, priority-encode, rotate back).
// Ports: valid_i[N], ptr_i -> grant_o (one-hot), gid_o (encoded), any_o.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] gid_o,
  output logic          any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             sel;

  always_comb begin
    dbl     = {valid_i, valid_i} >> ptr_i;
    rot     = dbl[N-1:0];
    any_o   = 1'b0;
    off     = 0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        off   = k;
      end
    end
    sel = off + int'(ptr_i);
    if (sel >= N) sel = sel - N;
    grant_o = '0;
    for (int k = 0; k < N; k++) begin
      grant_o[k] = any_o && (sel == k);
    end
    gid_o = any_o ? IW'(sel) : '0;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among N_REQ valid/ready requesters; 1-cycle reads.
// Ports: req_* in, req_ready/rsp_* out, sram_* to/from SRAM, busy. Macro SRAM_ARB_FIXED_PRIO_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int IW     = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*WIDTH-1:0]  req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [WIDTH-1:0]        sram_d,
  output logic                    sram_ren,
  output logic                    sram_wen,
  input  logic [WIDTH-1:0]        sram_q,
  output logic                    busy
);

  logic [N_REQ-1:0] valid_eff;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gid;
  logic [IW-1:0]    ptr_sel;
  logic             any_g;
  logic             g_we;
  logic             rd_pending_q, rd_pending_d;
  logic [IW-1:0]    rd_id_q, rd_id_d;
  logic             rsp_live;

  // Nothing is granted while reset is held.
  assign valid_eff = rst ? '0 : req_valid;

  rr_pick #(.N(N_REQ)) u_pick (
    .valid_i (valid_eff),
    .ptr_i   (ptr_sel),
    .grant_o (grant),
    .gid_o   (gid),
    .any_o   (any_g)
  );

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign ptr_sel = IW'(PTR_RESET);
`else
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (any_g) begin
      ptr_d = (gid == IW'(N_REQ - 1)) ? '0 : gid + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(PTR_RESET);
    else     ptr_q <= ptr_d;
  end

  assign ptr_sel = ptr_q;
`endif

  always_comb begin
    g_we      = 1'b0;
    sram_addr = '0;
    sram_d    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        g_we      = req_we[i];
        sram_addr = req_addr[i*ADDR_W +: ADDR_W];
        sram_d    = req_we[i] ? req_wdata[i*WIDTH +: WIDTH] : '0;
      end
    end
    sram_wen = any_g & g_we;
    sram_ren = any_g & ~g_we;
  end

  always_comb begin
    rd_pending_d = any_g & ~g_we;
    rd_id_d      = rd_pending_d ? gid : rd_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
      rd_id_q      <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_id_q      <= rd_id_d;
    end
  end

  // A read granted just before reset must not surface its data.
  assign rsp_live = rd_pending_q & ~rst;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = rsp_live && (rd_id_q == IW'(i));
    end
  end

  assign rsp_data  = rsp_live ? sram_q : WIDTH'(RSP_IDLE_DATA);
  assign req_ready = grant;
  assign busy      = ~rst & ((|req_valid) | rd_pending_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM.
// Table vectors plus hand sequences for multi-cycle cases.
module tb_sram_port_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [W-1:0]  rsp_data, sram_d, sram_q;
  logic [AW-1:0] sram_addr;
  logic          sram_ren, sram_wen, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mem [32];

  always #5 clk = ~clk;

  sram_port_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .sram_addr (sram_addr),
    .sram_d    (sram_d),
    .sram_ren  (sram_ren),
    .sram_wen  (sram_wen),
    .sram_q    (sram_q),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_d;
    if (sram_ren) sram_q <= mem[sram_addr];
  end

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  we;
    logic [4:0]  base;
    logic [3:0]  rdy;
    logic        ren;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] d;
    logic [3:0]  rspv;
    logic [31:0] rspd;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_excl();
    chk("ren_wen_excl", {31'b0, sram_ren & sram_wen}, 32'd0);
  endtask

  task automatic set_reqs(input logic [3:0] v, input logic [3:0] we,
                          input logic [4:0] base);
    req_valid = v;
    req_we    = we;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = base + 5'(i);
      req_wdata[i*W +: W]   = 32'h1000 * (i + 1) + 32'(base);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_reqs(4'b0, 4'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] prev_g;
  int wk, rk, got;
  int rq [$];

  initial begin
    rst = 1'b1;
    set_reqs(4'b0, 4'b0, 5'd0);

    tbl[0] = '{4'b0000, 4'b0000, 5'd0, 4'b0000, 0, 0, 5'd0, 32'h0,    4'b0000, 32'h0};
    tbl[1] = '{4'b1111, 4'b1111, 5'd0, 4'b0001, 0, 1, 5'd0, 32'h1000, 4'b0000, 32'h0};
    tbl[2] = '{4'b1111, 4'b1111, 5'd0, 4'b0010, 0, 1, 5'd1, 32'h2000, 4'b0000, 32'h0};
    tbl[3] = '{4'b0001, 4'b0000, 5'd0, 4'b0001, 1, 0, 5'd0, 32'h0,    4'b0000, 32'h0};
    tbl[4] = '{4'b0000, 4'b0000, 5'd0, 4'b0000, 0, 0, 5'd0, 32'h0,    4'b0001, 32'h1000};
    tbl[5] = '{4'b0011, 4'b0000, 5'd0, 4'b0010, 1, 0, 5'd1, 32'h0,    4'b0000, 32'h0};
    tbl[6] = '{4'b0011, 4'b0000, 5'd0, 4'b0001, 1, 0, 5'd0, 32'h0,    4'b0010, 32'h2000};
    tbl[7] = '{4'b1000, 4'b1000, 5'd4, 4'b1000, 0, 1, 5'd7, 32'h4004, 4'b0001, 32'h1000};
    tbl[8] = '{4'b1000, 4'b0000, 5'd4, 4'b1000, 1, 0, 5'd7, 32'h0,    4'b0000, 32'h0};
    tbl[9] = '{4'b0000, 4'b0000, 5'd0, 4'b0000, 0, 0, 5'd0, 32'h0,    4'b1000, 32'h4004};

    // Reset state, with requests asserted during reset.
    @(negedge clk);
    set_reqs(4'b1111, 4'b0000, 5'd0);
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv",  32'(rsp_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ren",   32'(sram_ren), 32'd0);
    chk("rst_wen",   32'(sram_wen), 32'd0);
    do_reset();

`ifndef SRAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      set_reqs(tbl[k].v, tbl[k].we, tbl[k].base);
      #2;
      chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(tbl[k].rdy));
      chk($sformatf("v%0d_ren", k),   32'(sram_ren),  32'(tbl[k].ren));
      chk($sformatf("v%0d_wen", k),   32'(sram_wen),  32'(tbl[k].wen));
      chk($sformatf("v%0d_addr", k),  32'(sram_addr), 32'(tbl[k].addr));
      chk($sformatf("v%0d_d", k),     sram_d,         tbl[k].d);
      chk($sformatf("v%0d_rspv", k),  32'(rsp_valid), 32'(tbl[k].rspv));
      chk($sformatf("v%0d_rspd", k),  rsp_data,       tbl[k].rspd);
      chk($sformatf("v%0d_busy", k),  32'(busy),
          32'((|tbl[k].v) | (|tbl[k].rspv)));
      chk_excl();
    end
`endif

    // Single write then read, requester 1, address 5.
    do_reset();
    set_reqs(4'b0010, 4'b0010, 5'd4);
    req_wdata[1*W +: W] = 32'hDEAD;
    #2;
    chk("wr_ready", 32'(req_ready), 32'b0010);
    chk("wr_wen",   32'(sram_wen), 32'd1);
    chk("wr_addr",  32'(sram_addr), 32'd5);
    chk_excl();
    @(negedge clk);
    set_reqs(4'b0010, 4'b0000, 5'd4);
    #2;
    chk("rd_ready", 32'(req_ready), 32'b0010);
    chk("rd_ren",   32'(sram_ren), 32'd1);
    chk("rd_d",     sram_d, 32'd0);
    chk_excl();
    @(negedge clk);
    set_reqs(4'b0000, 4'b0000, 5'd0);
    #2;
    chk("wr_rd_rspv", 32'(rsp_valid), 32'b0010);
    chk("wr_rd_data", rsp_data, 32'hDEAD);
    @(negedge clk);
    #2;
    chk("wr_rd_once", 32'(rsp_valid), 32'd0);

    // Full load, reads only.
    do_reset();
    prev_g = 4'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      set_reqs(4'b1111, 4'b0000, 5'd0);
      #2;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk($sformatf("full_g%0d", c), 32'(req_ready), 32'b0001);
`else
      chk($sformatf("full_g%0d", c), 32'(req_ready), 32'(4'b0001 << (c % 4)));
`endif
      chk($sformatf("full_rsp%0d", c), 32'(rsp_valid), 32'(prev_g));
      chk_excl();
      prev_g = req_ready;
    end

    // Sparse: only requesters 2 and 3.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      set_reqs(4'b1100, 4'b0000, 5'd0);
      #2;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk($sformatf("sparse_g%0d", c), 32'(req_ready), 32'b0100);
`else
      chk($sformatf("sparse_g%0d", c), 32'(req_ready), 32'(4'b0100 << (c % 2)));
`endif
    end
    @(negedge clk);
    set_reqs(4'b1111, 4'b0000, 5'd0);
    #2;
    chk("sparse_ptr0", 32'(req_ready), 32'b0001);

    // Reset while a read is outstanding.
    do_reset();
    set_reqs(4'b0010, 4'b0000, 5'd0);
    #2;
    chk("rmr_pre", 32'(req_ready), 32'b0010);
    @(negedge clk);
    set_reqs(4'b0001, 4'b0000, 5'd0);
    #2;
    chk("rmr_T", 32'(req_ready), 32'b0001);
    @(negedge clk);
    rst = 1'b1;
    set_reqs(4'b1111, 4'b0000, 5'd0);
    #2;
    chk("rmr_rspv",  32'(rsp_valid), 32'd0);
    chk("rmr_rspd",  rsp_data, 32'd0);
    chk("rmr_ready", 32'(req_ready), 32'd0);
    chk("rmr_busy",  32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rmr_post_g",    32'(req_ready), 32'b0001);
    chk("rmr_post_rspv", 32'(rsp_valid), 32'd0);

    // Mixed stream: req0 writes addr*3, req1 reads behind it.
    do_reset();
    wk = 0; rk = 0; got = 0;
    for (int c = 0; c < 300 && got < 32; c++) begin
      if (c > 0) @(negedge clk);
      req_valid = {2'b00, rk < wk, wk < 32};
      req_we    = 4'b0001;
      req_addr  = '0;
      req_wdata = '0;
      req_addr[0 +: AW]  = AW'(wk);
      req_addr[AW +: AW] = AW'(rk);
      req_wdata[0 +: W]  = 32'(wk * 3);
      #2;
      chk_excl();
      if (rsp_valid != 4'b0) begin
        if (rsp_valid != 4'b0010 || rq.size() == 0) begin
          chk("mix_rspv", 32'(rsp_valid), 32'b0010);
        end else begin
          chk($sformatf("mix_a%0d", rq[0]), rsp_data, 32'(rq[0] * 3));
          void'(rq.pop_front());
          got++;
        end
      end
      if (req_valid[0] && req_ready[0]) wk++;
      if (req_valid[1] && req_ready[1]) begin
        rq.push_back(rk);
        rk++;
      end
    end
    chk("mix_count", 32'(got), 32'd32);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
